// File: rtl/immediate_former_sequencer.sv
// Sequences LUI/AUIPC through the shared immediate former: accept, execute one cycle,
// then hand the result to the register file with an optional acknowledge timeout.

package immediate_former_sequencer_pkg;

    typedef enum logic {
        LUI   = 1'b0,
        AUIPC = 1'b1
    } ImmediateFormerMode_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EXECUTE   = 2'd1,
        WRITEBACK = 2'd2
    } seq_state_t;

    localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;

endpackage

module immediate_former_sequencer
    import immediate_former_sequencer_pkg::*;
#(
    parameter int ACK_TIMEOUT        = 15,
    parameter int RETIRE_COUNT_WIDTH = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic [31:0]                   instruction,
    input  logic [31:0]                   pc_in,
    output ImmediateFormerMode_t          immediate_former_mode,
    output logic [31:0]                   immediate_u,
    output logic [31:0]                   pc_of_instruction,
    input  logic [31:0]                   immediate_former_output,
    output logic                          rd_write_enable,
    output logic [4:0]                    rd_address,
    output logic [31:0]                   rd_data,
    input  logic                          rd_write_ack,
    output logic                          illegal_instruction,
    output logic                          writeback_timeout,
    output logic                          busy,
    output logic [RETIRE_COUNT_WIDTH-1:0] retired_count
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    seq_state_t                    state_q,    state_d;
    ImmediateFormerMode_t          mode_q,     mode_d;
    logic [31:0]                   imm_u_q,    imm_u_d;
    logic [31:0]                   pc_q,       pc_d;
    logic                          rd_we_q,    rd_we_d;
    logic [4:0]                    rd_addr_q,  rd_addr_d;
    logic [31:0]                   rd_data_q,  rd_data_d;
    logic                          illegal_q,  illegal_d;
    logic                          timeout_q,  timeout_d;
    logic [RETIRE_COUNT_WIDTH-1:0] retired_q,  retired_d;
    logic [CNT_W-1:0]              wb_cnt_q,   wb_cnt_d;

    logic       handshake;
    logic [6:0] opcode;

    assign instr_ready = (state_q == IDLE) && reset;
    assign handshake   = instr_valid && instr_ready;
    assign opcode      = instruction[6:0];

    always_comb begin
        // NOTE: every _d takes its hold value first so no path through the case infers a latch.
        state_d   = state_q;
        mode_d    = mode_q;
        imm_u_d   = imm_u_q;
        pc_d      = pc_q;
        rd_we_d   = rd_we_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        illegal_d = 1'b0;
        timeout_d = timeout_q;
        retired_d = retired_q;
        wb_cnt_d  = wb_cnt_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    if (opcode == OPCODE_LUI || opcode == OPCODE_AUIPC) begin
                        mode_d    = (opcode == OPCODE_LUI) ? LUI : AUIPC;
                        imm_u_d   = {instruction[31:12], 12'b0};
                        pc_d      = pc_in;
                        rd_addr_d = instruction[11:7];
                        state_d   = EXECUTE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end

            EXECUTE: begin
                rd_data_d = immediate_former_output;
                wb_cnt_d  = '0;
                if (rd_addr_q == 5'd0) begin
                    retired_d = retired_q + RETIRE_COUNT_WIDTH'(1);
                    state_d   = IDLE;
                end else begin
                    rd_we_d = 1'b1;
                    state_d = WRITEBACK;
                end
            end

            WRITEBACK: begin
                // An ack on the last permitted cycle still wins over the timeout.
                if (rd_write_ack) begin
                    rd_we_d   = 1'b0;
                    retired_d = retired_q + RETIRE_COUNT_WIDTH'(1);
                    state_d   = IDLE;
                end else if (ACK_TIMEOUT != 0 && wb_cnt_q == CNT_LAST) begin
                    rd_we_d   = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wb_cnt_d = wb_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                rd_we_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mode_q    <= LUI;
            imm_u_q   <= '0;
            pc_q      <= '0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
            wb_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            imm_u_q   <= imm_u_d;
            pc_q      <= pc_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            retired_q <= retired_d;
            wb_cnt_q  <= wb_cnt_d;
        end
    end

    assign immediate_former_mode = mode_q;
    assign immediate_u           = imm_u_q;
    assign pc_of_instruction     = pc_q;
    assign rd_write_enable       = rd_we_q;
    assign rd_address            = rd_addr_q;
    assign rd_data               = rd_data_q;
    assign illegal_instruction   = illegal_q;
    assign writeback_timeout     = timeout_q;
    assign busy                  = (state_q != IDLE);
    assign retired_count         = retired_q;

endmodule

// File: tb/tb_immediate_former_sequencer.sv
// Directed bench for immediate_former_sequencer with a behavioural immediate former
// and hand-computed expectations for each step.

module tb_immediate_former_sequencer;
    import immediate_former_sequencer_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 instr_valid = 1'b0;
    logic                 instr_ready;
    logic [31:0]          instruction = '0;
    logic [31:0]          pc_in = '0;
    ImmediateFormerMode_t immediate_former_mode;
    logic [31:0]          immediate_u;
    logic [31:0]          pc_of_instruction;
    logic [31:0]          immediate_former_output;
    logic                 rd_write_enable;
    logic [4:0]           rd_address;
    logic [31:0]          rd_data;
    logic                 rd_write_ack = 1'b0;
    logic                 illegal_instruction;
    logic                 writeback_timeout;
    logic                 busy;
    logic [31:0]          retired_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Behavioural immediate former: LUI passes the immediate, AUIPC adds the PC.
    assign immediate_former_output = (immediate_former_mode == AUIPC)
                                   ? immediate_u + pc_of_instruction : immediate_u;

    immediate_former_sequencer #(
        .ACK_TIMEOUT(15),
        .RETIRE_COUNT_WIDTH(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instruction(instruction),
        .pc_in(pc_in),
        .immediate_former_mode(immediate_former_mode),
        .immediate_u(immediate_u),
        .pc_of_instruction(pc_of_instruction),
        .immediate_former_output(immediate_former_output),
        .rd_write_enable(rd_write_enable),
        .rd_address(rd_address),
        .rd_data(rd_data),
        .rd_write_ack(rd_write_ack),
        .illegal_instruction(illegal_instruction),
        .writeback_timeout(writeback_timeout),
        .busy(busy),
        .retired_count(retired_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        instruction = instr;
        pc_in       = pc;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_ready", 32'(instr_ready), 32'd0);
        check("rst_we", 32'(rd_write_enable), 32'd0);
        check("rst_addr", 32'(rd_address), 32'd0);
        check("rst_data", rd_data, 32'd0);
        check("rst_imm", immediate_u, 32'd0);
        check("rst_pc", pc_of_instruction, 32'd0);
        check("rst_mode", 32'(immediate_former_mode), 32'(LUI));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_retired", retired_count, 32'd0);
        check("rst_timeout", 32'(writeback_timeout), 32'd0);
        check("rst_illegal", 32'(illegal_instruction), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // 1: LUI x5 with immediate ack
        rd_write_ack = 1'b1;
        check("t1_ready_idle", 32'(instr_ready), 32'd1);
        issue(32'h123452B7, 32'h100);
        check("t1_busy_exec", 32'(busy), 32'd1);
        check("t1_ready_exec", 32'(instr_ready), 32'd0);
        check("t1_we_exec", 32'(rd_write_enable), 32'd0);
        check("t1_imm", immediate_u, 32'h12345000);
        check("t1_pc", pc_of_instruction, 32'h100);
        check("t1_mode", 32'(immediate_former_mode), 32'(LUI));
        tick();
        check("t1_we", 32'(rd_write_enable), 32'd1);
        check("t1_addr", 32'(rd_address), 32'd5);
        check("t1_data", rd_data, 32'h12345000);
        tick();
        check("t1_we_done", 32'(rd_write_enable), 32'd0);
        check("t1_retired", retired_count, 32'd1);
        check("t1_ready_back", 32'(instr_ready), 32'd1);

        // 2: AUIPC x1 with ack delayed, then AUIPC that wraps
        rd_write_ack = 1'b0;
        issue(32'h00001097, 32'h80);
        check("t2_mode", 32'(immediate_former_mode), 32'(AUIPC));
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t2_we_hold", 32'(rd_write_enable), 32'd1);
            check("t2_data_hold", rd_data, 32'h00001080);
            check("t2_addr_hold", 32'(rd_address), 32'd1);
            if (i < 3) tick();
        end
        rd_write_ack = 1'b1;
        tick();
        rd_write_ack = 1'b0;
        check("t2_we_done", 32'(rd_write_enable), 32'd0);
        check("t2_retired", retired_count, 32'd2);
        rd_write_ack = 1'b1;
        issue(32'hFFFFF097, 32'h2000);
        tick();
        check("t2_wrap_data", rd_data, 32'h00001000);
        check("t2_wrap_we", 32'(rd_write_enable), 32'd1);
        tick();
        check("t2_wrap_retired", retired_count, 32'd3);

        // 3: illegal opcode (ADDI)
        issue(32'h00000013, 32'h300);
        check("t3_illegal", 32'(illegal_instruction), 32'd1);
        check("t3_we", 32'(rd_write_enable), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_ready", 32'(instr_ready), 32'd1);
        check("t3_retired", retired_count, 32'd3);
        tick();
        check("t3_illegal_pulse", 32'(illegal_instruction), 32'd0);

        // 4: LUI x0 retires without a write
        issue(32'h12345037, 32'h400);
        check("t4_busy", 32'(busy), 32'd1);
        tick();
        check("t4_we", 32'(rd_write_enable), 32'd0);
        check("t4_retired", retired_count, 32'd4);
        check("t4_ready", 32'(instr_ready), 32'd1);
        check("t4_data", rd_data, 32'h12345000);

        // 5a: ack on the final (15th) writeback cycle succeeds
        rd_write_ack = 1'b0;
        issue(32'hABCDE3B7, 32'h500);
        tick();
        for (int k = 1; k < 15; k++) begin
            check("t5a_we_wait", 32'(rd_write_enable), 32'd1);
            tick();
        end
        check("t5a_we_last", 32'(rd_write_enable), 32'd1);
        rd_write_ack = 1'b1;
        tick();
        rd_write_ack = 1'b0;
        check("t5a_we_done", 32'(rd_write_enable), 32'd0);
        check("t5a_retired", retired_count, 32'd5);
        check("t5a_no_timeout", 32'(writeback_timeout), 32'd0);

        // 5b: no ack -> timeout after 15 writeback cycles
        issue(32'hABCDE3B7, 32'h600);
        tick();
        for (int k = 1; k <= 15; k++) begin
            check("t5b_we_wait", 32'(rd_write_enable), 32'd1);
            check("t5b_timeout_low", 32'(writeback_timeout), 32'd0);
            tick();
        end
        check("t5b_we_drop", 32'(rd_write_enable), 32'd0);
        check("t5b_timeout", 32'(writeback_timeout), 32'd1);
        check("t5b_retired", retired_count, 32'd5);
        check("t5b_ready", 32'(instr_ready), 32'd1);
        issue(32'h12345037, 32'h700);
        tick();
        check("t5b_sticky", 32'(writeback_timeout), 32'd1);
        check("t5b_retired_after", retired_count, 32'd6);

        // 6: asynchronous reset in WRITEBACK
        issue(32'h123452B7, 32'h800);
        tick();
        check("t6_we_before", 32'(rd_write_enable), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_we", 32'(rd_write_enable), 32'd0);
        check("t6_addr", 32'(rd_address), 32'd0);
        check("t6_data", rd_data, 32'd0);
        check("t6_imm", immediate_u, 32'd0);
        check("t6_pc", pc_of_instruction, 32'd0);
        check("t6_mode", 32'(immediate_former_mode), 32'(LUI));
        check("t6_timeout", 32'(writeback_timeout), 32'd0);
        check("t6_retired", retired_count, 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ready", 32'(instr_ready), 32'd0);
        #2 reset = 1'b1;
        tick();
        rd_write_ack = 1'b1;
        issue(32'h000011B7, 32'h900);
        tick();
        check("t6_new_we", 32'(rd_write_enable), 32'd1);
        check("t6_new_addr", 32'(rd_address), 32'd3);
        check("t6_new_data", rd_data, 32'h00001000);
        tick();
        check("t6_new_retired", retired_count, 32'd1);
        check("t6_new_we_done", 32'(rd_write_enable), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
